uart_rx_ctrl: RTL

- Frame controller for the UART receiver. Detects the start condition on the serial line and runs the per-bit edge counter and the per-frame bit counter.
- Drives the sampler's enable and edge-count inputs, and consumes the sampler's majority-vote bit at the end of every bit period.
- Deserializes data LSB-first and checks start glitch, parity and stop bit.
- Sits between the RX pin synchronizer/sampler and the processing unit's receive interface.

---
 rtl/uart_rx_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: start detection, per-bit edge counting,
// LSB-first deserialization and parity/stop checking.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rx,
  input  logic [PRESC_W-1:0]    i_prescale,
  input  logic                  i_par_en,
  input  logic                  i_par_typ,
  input  logic                  i_sampled_bit,
  output logic                  o_en_samp,
  output logic [PRESC_W-1:0]    o_edge_cnt,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_data_valid,
  output logic                  o_par_err,
  output logic                  o_stp_err,
  output logic                  o_busy
);

  localparam int BC_W = $clog2(DATA_WIDTH + 1);
  localparam logic [PRESC_W-1:0] LAST_X8  = PRESC_W'(7);
  localparam logic [PRESC_W-1:0] LAST_X16 = PRESC_W'(15);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                  state_q;
  logic [PRESC_W-1:0]      edge_q;
  logic [PRESC_W-1:0]      last_q;
  logic [BC_W-1:0]         bit_q;
  logic [DATA_WIDTH-1:0]   shift_q;
  logic [DATA_WIDTH-1:0]   shift_d;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    par_en_q;
  logic                    par_typ_q;
  logic                    mism_q;
  logic                    valid_q;
  logic                    par_err_q;
  logic                    stp_err_q;
  logic                    busy_q;
  logic                    bit_end;

  // Only x16 is honoured; every other prescale value runs at x8.
  function automatic logic [PRESC_W-1:0] last_edge(input logic [PRESC_W-1:0] presc);
    return (presc == PRESC_W'(16)) ? LAST_X16 : LAST_X8;
  endfunction

  function automatic logic exp_parity(input logic [DATA_WIDTH-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  always_comb begin
    logic [DATA_WIDTH:0] ext;
    ext     = {i_sampled_bit, shift_q};
    shift_d = ext[DATA_WIDTH:1];
  end

  assign bit_end = (edge_q == last_q);

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q   <= S_IDLE;
      edge_q    <= '0;
      last_q    <= LAST_X8;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      mism_q    <= 1'b0;
      valid_q   <= 1'b0;
      par_err_q <= 1'b0;
      stp_err_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      par_err_q <= 1'b0;
      stp_err_q <= 1'b0;
      if (state_q == S_IDLE) begin
        edge_q <= '0;
        if (!i_rx) begin
          state_q   <= S_START;
          busy_q    <= 1'b1;
          last_q    <= last_edge(i_prescale);
          par_en_q  <= i_par_en;
          par_typ_q <= i_par_typ;
          mism_q    <= 1'b0;
        end
      end else begin
        edge_q <= bit_end ? '0 : edge_q + PRESC_W'(1);
        if (bit_end) begin
          case (state_q)
            S_START: begin
              // A high vote at the end of the start bit means the low was a glitch.
              if (i_sampled_bit) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end else begin
                state_q <= S_DATA;
                bit_q   <= '0;
              end
            end
            S_DATA: begin
              shift_q <= shift_d;
              bit_q   <= bit_q + BC_W'(1);
              if (bit_q == BC_W'(DATA_WIDTH - 1)) begin
                state_q <= par_en_q ? S_PARITY : S_STOP;
              end
            end
            S_PARITY: begin
              mism_q  <= (exp_parity(shift_q, par_typ_q) != i_sampled_bit);
              state_q <= S_STOP;
            end
            S_STOP: begin
              // Stop error outranks parity error; only one result pulse per frame.
              if (!i_sampled_bit) begin
                stp_err_q <= 1'b1;
              end else if (mism_q) begin
                par_err_q <= 1'b1;
              end else begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
              end
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
            default: begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign o_en_samp    = busy_q;
  assign o_busy       = busy_q;
  assign o_edge_cnt   = edge_q;
  assign o_data       = data_q;
  assign o_data_valid = valid_q;
  assign o_par_err    = par_err_q;
  assign o_stp_err    = stp_err_q;

endmodule
